// File: rtl/serializer_arbiter.sv
// rtl/serializer_arbiter.sv - round-robin frame scheduler sharing one downstream serializer
// Optional stall timeout with frame_err output: define SERIALIZER_ARBITER_TIMEOUT_EN.
module serializer_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int DATA_W          = 8,
  parameter int WORDS_PER_FRAME = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int TIMEOUT         = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC-1:0]          req,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ack,
  output logic [NUM_SRC-1:0]          grant,
  output logic [$clog2(NUM_SRC)-1:0]  cur_src,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy
`ifdef SERIALIZER_ARBITER_TIMEOUT_EN
  ,
  output logic                        frame_err
`endif
);

  localparam int SW  = $clog2(NUM_SRC);
  localparam int WCW = $clog2(WORDS_PER_FRAME) + 1;
  localparam int GCW = $clog2(GAP_CYCLES + 1) + 1;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] grant_nxt;
  logic [SW-1:0]      cur_src_nxt;
  logic [SW-1:0]      rr_ptr, rr_ptr_nxt;
  logic [SW-1:0]      pick_idx, ptr_inc;
  logic               pick_found;
  logic [WCW-1:0]     word_cnt, word_cnt_nxt;
  logic [GCW-1:0]     gap_cnt, gap_cnt_nxt;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               held, hs, frame_end;
  logic               stall_abort;

  // First set request at or after ptr, wrapping; scanning downward lets the nearest one win.
  function automatic logic [SW:0] rr_pick(input logic [NUM_SRC-1:0] r, input logic [SW-1:0] ptr);
    logic [SW:0] res;
    int k;
    res = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NUM_SRC) k = k - NUM_SRC;
      if (r[k[SW-1:0]]) res = {1'b1, k[SW-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_src == SW'(i)) begin
        sel_data  = src_data[i*DATA_W +: DATA_W];
        sel_valid = src_valid[i];
      end
    end
  end

  assign held      = |grant;
  assign out_valid = held & sel_valid;
  assign out_data  = held ? sel_data : '0;
  assign hs        = out_valid & out_ready;
  assign src_ack   = hs ? grant : '0;
  assign out_last  = out_valid & (word_cnt == WCW'(WORDS_PER_FRAME - 1));
  assign busy      = (state != IDLE);
  assign ptr_inc   = (cur_src == SW'(NUM_SRC - 1)) ? '0 : cur_src + 1'b1;

`ifdef SERIALIZER_ARBITER_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1) + 1;
  logic [TCW-1:0] stall_cnt;

  // Abort fires during the TIMEOUT-th consecutive stalled cycle.
  assign stall_abort = (state == XFER) && !sel_valid && (int'(stall_cnt) + 1 >= TIMEOUT);
  assign frame_err   = stall_abort;

  always_ff @(posedge clk) begin
    if (rst || state != XFER || sel_valid) stall_cnt <= '0;
    else                                    stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign stall_abort = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    cur_src_nxt  = cur_src;
    rr_ptr_nxt   = rr_ptr;
    word_cnt_nxt = word_cnt;
    gap_cnt_nxt  = gap_cnt;
    frame_end    = 1'b0;
    {pick_found, pick_idx} = rr_pick(req, rr_ptr);
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt           = XFER;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          cur_src_nxt         = pick_idx;
          word_cnt_nxt        = '0;
        end
      end
      XFER: begin
        if (hs) begin
          word_cnt_nxt = word_cnt + 1'b1;
          frame_end    = out_last;
        end
        if (stall_abort) frame_end = 1'b1;
        if (frame_end) begin
          grant_nxt   = '0;
          rr_ptr_nxt  = ptr_inc;
          gap_cnt_nxt = '0;
          state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (int'(gap_cnt) + 1 >= GAP_CYCLES) state_nxt = IDLE;
        else                                 gap_cnt_nxt = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      cur_src  <= '0;
      rr_ptr   <= '0;
      word_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      cur_src  <= cur_src_nxt;
      rr_ptr   <= rr_ptr_nxt;
      word_cnt <= word_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_serializer_arbiter.sv
// tb/tb_serializer_arbiter.sv - scoreboard bench for serializer_arbiter (default and zero-gap builds)
module tb_serializer_arbiter;

  localparam int WPF = 4;
  localparam int GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, out_ready, out_valid, out_last, busy;
  logic [3:0]  req, src_valid, src_ack, grant;
  logic [31:0] src_data;
  logic [1:0]  cur_src;
  logic [7:0]  out_data;

  logic        rst_z, out_ready_z, out_valid_z, out_last_z, busy_z;
  logic [3:0]  req_z, src_valid_z, src_ack_z, grant_z;
  logic [31:0] src_data_z;
  logic [1:0]  cur_src_z;
  logic [7:0]  out_data_z;

  serializer_arbiter #(.NUM_SRC(4), .DATA_W(8), .WORDS_PER_FRAME(WPF), .GAP_CYCLES(GAP), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .src_valid(src_valid), .src_data(src_data),
    .src_ack(src_ack), .grant(grant), .cur_src(cur_src), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  serializer_arbiter #(.NUM_SRC(4), .DATA_W(8), .WORDS_PER_FRAME(WPF), .GAP_CYCLES(0), .TIMEOUT(16)) dut_z (
    .clk(clk), .rst(rst_z), .req(req_z), .src_valid(src_valid_z), .src_data(src_data_z),
    .src_ack(src_ack_z), .grant(grant_z), .cur_src(cur_src_z), .out_data(out_data_z),
    .out_valid(out_valid_z), .out_ready(out_ready_z), .out_last(out_last_z), .busy(busy_z)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         src;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_cyc = -1;
  logic [3:0] wcnt[4];
  logic [3:0] ecnt[4];
  logic [3:0] prev_grant;
  logic       toggle_en;
  logic       hold_valid;
  logic [7:0] hold_data;

  // Each source presents {source id, running word count}; the count advances on its ack.
  assign src_data = {4'd3, wcnt[3], 4'd2, wcnt[2], 4'd1, wcnt[1], 4'd0, wcnt[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int s, input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.data = {s[3:0], ecnt[s[1:0]]};
      e.last = (j == WPF - 1);
      e.src  = s;
      sb.push_back(e);
      ecnt[s[1:0]] = ecnt[s[1:0]] + 4'd1;
    end
  endtask

  task automatic tick();
    int   acked;
    exp_t e;
    acked = -1;
    @(negedge clk);
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      chk("ack_mask", 32'(src_ack), (out_valid && out_ready) ? 32'(grant) : 32'd0);
      if (hold_valid) chk("hold_data", 32'(out_data), 32'(hold_data));
      hold_valid = out_valid && !out_ready;
      hold_data  = out_data;
      if (out_valid && out_ready) begin
        acked = int'(cur_src);
        if (sb.size() == 0) begin
          chk("unexpected_hs", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("data", 32'(out_data), 32'(e.data));
          chk("last", 32'(out_last), 32'(e.last));
          chk("grant_owner", 32'(grant), 32'd1 << e.src);
          if (out_last) last_cyc = cyc + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acked >= 0) wcnt[acked[1:0]] = wcnt[acked[1:0]] + 4'd1;
    if (grant != 4'd0 && prev_grant == 4'd0 && last_cyc >= 0)
      chk("gap_latency", 32'(cyc - last_cyc), 32'(GAP + 1));
    prev_grant = grant;
    if (toggle_en) out_ready = !out_ready;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'd0; src_valid = 4'hf; out_ready = 1'b1; toggle_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    last_cyc = -1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      wcnt[i] = 4'd0;
      ecnt[i] = 4'd0;
    end
    prev_grant = 4'd0; hold_valid = 1'b0; hold_data = 8'd0; toggle_en = 1'b0;
    rst_z = 1'b1; req_z = 4'd0; src_valid_z = 4'hf; out_ready_z = 1'b1;
    src_data_z = 32'hD3C2B1A0;

    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_cur_src", 32'(cur_src), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_src_ack", 32'(src_ack), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single requester: one frame, then two gap cycles, then idle.
    req = 4'b0001;
    push_frame(0, 4);
    tick();
    chk("t1_grant", 32'(grant), 32'b0001);
    chk("t1_busy", 32'(busy), 32'd1);
    drain(20);
    req = 4'd0;
    chk("t1_gap_grant", 32'(grant), 32'd0);
    chk("t1_gap1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_gap2_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // All four requesting: round-robin 0, 1, 2.
    do_reset();
    req = 4'hf;
    push_frame(0, 4);
    push_frame(1, 4);
    push_frame(2, 4);
    drain(60);
    req = 4'd0;
    tick();
    tick();
    chk("t2_idle_busy", 32'(busy), 32'd0);
    chk("t2_idle_grant", 32'(grant), 32'd0);

    // Backpressure: ready alternates starting low, so the frame spans 8 cycles.
    req = 4'b0010;
    push_frame(1, 4);
    tick();
    chk("t3_grant", 32'(grant), 32'b0010);
    out_ready = 1'b0;
    toggle_en = 1'b1;
    n = 0;
    while (grant != 4'd0 && n < 20) begin
      tick();
      n++;
    end
    toggle_en = 1'b0;
    out_ready = 1'b1;
    req = 4'd0;
    chk("t3_frame_cycles", 32'(n), 32'd8);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    tick();
    tick();

    // Reset after two words truncates the frame; next request is served normally.
    req = 4'b1000;
    push_frame(3, 2);
    tick();
    chk("t4_grant", 32'(grant), 32'b1000);
    drain(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_cyc = -1;
    chk("t4_rst_grant", 32'(grant), 32'd0);
    chk("t4_rst_valid", 32'(out_valid), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_last", 32'(out_last), 32'd0);
    chk("t4_rst_cur_src", 32'(cur_src), 32'd0);
    req = 4'b0100;
    push_frame(2, 4);
    tick();
    chk("t4_regrant", 32'(grant), 32'b0100);
    drain(20);
    req = 4'd0;
    tick();
    tick();

    // Zero-gap build: src1 granted on the edge right after src0's closing IDLE cycle.
    tick();
    rst_z = 1'b0;
    req_z = 4'b0011;
    tick();
    chk("z_grant0", 32'(grant_z), 32'b0001);
    n = 0;
    while (!out_last_z && n < 20) begin
      tick();
      n++;
    end
    chk("z_words_before_last", 32'(n), 32'd3);
    chk("z_last_data", 32'(out_data_z), 32'hA0);
    chk("z_last_ack", 32'(src_ack_z), 32'b0001);
    tick();
    chk("z_after_last_grant", 32'(grant_z), 32'd0);
    chk("z_after_last_busy", 32'(busy_z), 32'd0);
    tick();
    chk("z_grant1", 32'(grant_z), 32'b0010);
    chk("z_cur_src1", 32'(cur_src_z), 32'd1);

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
